// File: rtl/sig_event_det_pkg.sv
// Shared types and helpers for the multi-channel signal event detector.
package sig_event_det_pkg;

    localparam int DET_MODE_W = 3;

    typedef enum logic [DET_MODE_W-1:0] {
        DET_LOW  = 3'd0,
        DET_HIGH = 3'd1,
        DET_RISE = 3'd2,
        DET_FALL = 3'd3,
        DET_BOTH = 3'd4
    } det_mode_e;

    // Condition for one channel given its filtered value and the value one cycle earlier.
    // Codes 5..7 are reserved and never fire.
    function automatic logic det_cond(logic [DET_MODE_W-1:0] mode, logic fv, logic fv_d);
        logic r;
        r = 1'b0;
        case (mode)
            DET_LOW:  r = ~fv;
            DET_HIGH: r = fv;
            DET_RISE: r = fv & ~fv_d;
            DET_FALL: r = ~fv & fv_d;
            DET_BOTH: r = fv ^ fv_d;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sig_event_detector_if.sv
// Control/status bundle of the signal event detector.
// master = register block / stimulus side, slave = detector.
interface sig_event_detector_if
    import sig_event_det_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int FILT_W = 4
);
    logic [NUM_CH-1:0]            i_en;
    logic [DET_MODE_W*NUM_CH-1:0] i_mode;
    logic [FILT_W-1:0]            i_filt_len;
    logic [NUM_CH-1:0]            i_sig_in;
    logic [NUM_CH-1:0]            i_sts_clr;
    logic [NUM_CH-1:0]            o_detect;
    logic [NUM_CH-1:0]            o_sts;
    logic                         o_irq;

    modport master (
        output i_en, i_mode, i_filt_len, i_sig_in, i_sts_clr,
        input  o_detect, o_sts, o_irq
    );

    modport slave (
        input  i_en, i_mode, i_filt_len, i_sig_in, i_sts_clr,
        output o_detect, o_sts, o_irq
    );
endinterface

// File: rtl/sig_filter_ch.sv
// One channel: input synchroniser, glitch filter and one-cycle delay of the filtered value.
// Optional macro SIG_EVENT_DET_SYNC2_EN adds a second synchroniser flop for asynchronous pins.
module sig_filter_ch #(
    parameter int   FILT_W  = 4,
    parameter logic RST_LVL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sig,
    input  logic [FILT_W-1:0] i_filt_len,
    output logic              o_fv,
    output logic              o_fv_d
);
    localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

    logic              s1;
    logic              s_flt;
    logic [FILT_W-1:0] cnt;

`ifdef SIG_EVENT_DET_SYNC2_EN
    logic s2;

    // Second synchroniser stage for truly asynchronous inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) s2 <= RST_LVL;
        else       s2 <= s1;
    end

    assign s_flt = s2;
`else
    assign s_flt = s1;
`endif

    // Filtered value follows the synchronised input only after it has disagreed for L+1
    // consecutive cycles; cnt >= L also covers L being lowered below a running count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1     <= RST_LVL;
            cnt    <= '0;
            o_fv   <= RST_LVL;
            o_fv_d <= RST_LVL;
        end else begin
            s1     <= i_sig;
            o_fv_d <= o_fv;
            if (s_flt == o_fv) begin
                cnt <= '0;
            end else if (cnt >= i_filt_len) begin
                o_fv <= s_flt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/sig_event_detector.sv
// Multi-channel event detector: per-channel filter, mode decode, registered detect,
// sticky status with clear, and a single interrupt.
// Optional macro SIG_EVENT_DET_SYNC2_EN (in sig_filter_ch) adds one cycle of latency.
module sig_event_detector
    import sig_event_det_pkg::*;
#(
    parameter int   NUM_CH  = 4,
    parameter int   FILT_W  = 4,
    parameter logic RST_LVL = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sig_event_detector_if.slave  bus
);
    logic [NUM_CH-1:0] fv;
    logic [NUM_CH-1:0] fv_d;
    logic [NUM_CH-1:0] cond;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] sts_next;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sig_filter_ch #(
            .FILT_W  (FILT_W),
            .RST_LVL (RST_LVL)
        ) u_filt (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_sig      (bus.i_sig_in[c]),
            .i_filt_len (bus.i_filt_len),
            .o_fv       (fv[c]),
            .o_fv_d     (fv_d[c])
        );

        assign cond[c] = det_cond(bus.i_mode[DET_MODE_W*c +: DET_MODE_W], fv[c], fv_d[c]);
    end

    // Filtering runs regardless of enable; only the qualified hit is gated.
    assign hit = bus.i_en & cond;

    // A new hit outranks a clear arriving in the same cycle.
    always_comb begin
        sts_next = (bus.o_sts & ~bus.i_sts_clr) | hit;
    end

    // Registered outputs; irq is taken from next-state status so it moves with o_sts.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_detect <= '0;
            bus.o_sts    <= '0;
            bus.o_irq    <= 1'b0;
        end else begin
            bus.o_detect <= hit;
            bus.o_sts    <= sts_next;
            bus.o_irq    <= |sts_next;
        end
    end
endmodule

// File: doc/sig_event_detector.md
Name: sig_event_detector

Overview:
Parametrised multi-channel successor to the single-bit low-level detector used in the APB Timer input path. Each channel:
- samples an external signal;
- applies a programmable glitch filter;
- detects a per-channel selectable condition: low level, high level, rising edge, falling edge or both edges.

Outputs are a registered per-channel detect, sticky status bits with clear, and a single interrupt line for the timer register block.

Parameters:
NUM_CH, 4, number of independent channels (1..32)
FILT_W, 4, width of filter-length field; max filter length 2**FILT_W-1
RST_LVL, 1'b0, reset/idle value loaded into every channel's sync, filtered and delayed registers

Ports:
i_clk  input  1  system clock, all logic rising-edge
i_rst  input  1  synchronous, active-high reset
i_en  input  NUM_CH  per-channel detect enable
i_mode  input  3*NUM_CH  per-channel mode, channel c at [3c+2:3c], encoding from package
i_filt_len  input  FILT_W  filter length L, shared by all channels
i_sig_in  input  NUM_CH  raw input signals
i_sts_clr  input  NUM_CH  per-channel sticky-status clear, one-cycle pulse
o_detect  output  NUM_CH  registered detect: pulse for edge modes, level for level modes
o_sts  output  NUM_CH  sticky status
o_irq  output  1  registered OR of o_sts

Behaviour:
- Reset, i_rst=1 at a clock edge:
  - sync, fv and fv_d registers load RST_LVL;
  - filter counters load 0;
  - o_detect, o_sts and o_irq load 0.
  - Applies mid-operation identically; no partial state survives.
- Sync stage: s1 <= i_sig_in every cycle.
- Filter, per channel, counter cnt of FILT_W bits:
  - s1==fv: cnt<=0.
  - else if cnt>=L: fv<=s1, cnt<=0.
  - else cnt<=cnt+1.
  - L=0 is a pure one-cycle follower.
  - fv changes only after s1 differs from fv for L+1 consecutive cycles. A single-cycle agreement restarts the count.
  - cnt never wraps.
  - L changed mid-count: comparison uses the new L immediately. cnt>=L covers the case where the new L is below the current cnt.
- Delay: fv_d <= fv.
- Conditions:
  - LOW = ~fv
  - HIGH = fv
  - RISE = fv & ~fv_d
  - FALL = ~fv & fv_d
  - BOTH = fv ^ fv_d
  - Reserved codes 5..7 give 0.
- Detect: o_detect[c] <= i_en[c] & cond[c].
- Latency: input change sampled at edge t reaches o_detect at edge t+2+L. Edge detects are exactly one cycle wide.
- Filtering runs regardless of i_en, so enabling a channel never produces a spurious edge.
- Changing mode takes effect on the next edge. No edge is synthesised from the mode change itself.
- Sticky status: o_sts[c] <= (o_sts[c] & ~i_sts_clr[c]) | (i_en[c] & cond[c]).
  - Set and clear in the same cycle: set wins.
  - o_sts rises on the same edge as o_detect.
- Interrupt: o_irq <= |(next o_sts). o_irq tracks o_sts with zero extra delay.

Optional Feature:
SIG_EVENT_DET_SYNC2_EN
- Defined: a second sync flop is inserted (s2 <= s1), the filter takes s2, and latency becomes t+3+L. s2 also resets to RST_LVL. Used for truly asynchronous pins.
- Undefined: single sync stage, latency t+2+L.

Decomposition:
- Package sig_event_det_pkg holds:
  - typedef enum logic [2:0] det_mode_e {DET_LOW=0, DET_HIGH=1, DET_RISE=2, DET_FALL=3, DET_BOTH=4};
  - localparam DET_MODE_W=3.
- Sub-module sig_filter_ch, one instance per channel via generate, contains:
  - sync stage(s), cnt, fv, fv_d;
  - outputs fv and fv_d.
- Top level holds the mode decode, o_detect, o_sts and o_irq.

Test Plan:
1. NUM_CH=4, L=0, ch0 DET_LOW, i_en=4'b0001; drive i_sig_in[0] 1->0 sampled at edge 10 -> o_detect[0]=1 from edge 12 while the input stays low, o_sts[0]=1 and o_irq=1 at edge 12.
2. L=3, ch1 DET_RISE; a 3-cycle high glitch -> no detect. A 4-cycle-or-longer high sampled from edge 20 -> single 1-cycle o_detect[1] pulse at edge 25.
3. ch2 DET_BOTH, L=0; input toggles every 4 cycles -> one o_detect[2] pulse per toggle, each 2 cycles after sampling.
4. o_sts[3] set; assert i_sts_clr[3] in the same cycle a new ch3 event is detected -> o_sts[3] stays 1. Clear alone in a later cycle -> o_sts[3]=0 and o_irq=0 next edge.
5. RST_LVL=0, input held high through reset, ch0 DET_RISE -> exactly one rise pulse at edge 2 after reset release. Assert i_rst mid-filter-count -> all outputs 0 next edge, no pulse.
6. i_en[1]=0 while its input toggles, then i_en[1]=1 with the input stable -> no o_detect and no o_sts. Mode code 3'd6 -> o_detect stays 0.
